// File: rtl/tree_pkg.sv
// Shared types and constants for the adder-tree feed path.
package tree_pkg;

    localparam int unsigned SAMPLE_W = 8;
    localparam int unsigned N_LANES  = 8;
    localparam int unsigned TREE_LAT = 3;
    localparam int unsigned SUM_W    = 11;
    localparam int unsigned FCNT_W   = 16;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef sample_t [N_LANES-1:0]      lanes_t;

    typedef enum logic {
        FILL = 1'b0,
        PAD  = 1'b1
    } state_e;

endpackage

// File: rtl/sample_window_loader_if.sv
// Sample stream in, parallel frame out, between the loader and its neighbours.
interface sample_window_loader_if;
    import tree_pkg::*;

    sample_t             in_data;
    logic                in_valid;
    logic                in_ready;
    logic                flush;
    sample_t             lane_0;
    sample_t             lane_1;
    sample_t             lane_2;
    sample_t             lane_3;
    sample_t             lane_4;
    sample_t             lane_5;
    sample_t             lane_6;
    sample_t             lane_7;
    logic                frame_valid;
    logic                frame_partial;
    logic                sum_valid;
    logic [FCNT_W-1:0]   frame_count;

    modport master (
        output in_data, in_valid, flush,
        input  in_ready,
        input  lane_0, lane_1, lane_2, lane_3, lane_4, lane_5, lane_6, lane_7,
        input  frame_valid, frame_partial, sum_valid, frame_count
    );

    modport slave (
        input  in_data, in_valid, flush,
        output in_ready,
        output lane_0, lane_1, lane_2, lane_3, lane_4, lane_5, lane_6, lane_7,
        output frame_valid, frame_partial, sum_valid, frame_count
    );

endinterface

// File: rtl/valid_delay.sv
// Single-bit DEPTH-stage shift register with synchronous clear, for latency alignment.
module valid_delay #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift the new bit in at stage 0.
    always_comb begin
        sr_d    = sr_q << 1;
        sr_d[0] = d;
    end

    // Stage registers; clear drops everything in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/sample_window_loader.sv
// Packs a serial signed sample stream into 8-lane frames for the adder tree.
module sample_window_loader
    import tree_pkg::sample_t, tree_pkg::state_e, tree_pkg::FILL, tree_pkg::PAD;
#(
    parameter int unsigned WIDTH    = tree_pkg::SAMPLE_W,
    parameter int unsigned LANES    = tree_pkg::N_LANES,
    parameter int unsigned TREE_LAT = tree_pkg::TREE_LAT
) (
    input logic                   clk,
    input logic                   rst,
    sample_window_loader_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(LANES);
    localparam int unsigned FCNT_W = tree_pkg::FCNT_W;

    typedef logic signed [WIDTH-1:0] lane_t;
    typedef logic [CNT_W-1:0]        cnt_t;

    localparam cnt_t LAST_IDX = cnt_t'(LANES - 1);

    state_e              state_q,         state_d;
    cnt_t                fill_cnt_q,      fill_cnt_d;
    lane_t               coll_q [LANES];
    lane_t               coll_d [LANES];
    lane_t               pres_q [LANES];
    lane_t               pres_d [LANES];
    logic                frame_valid_q,   frame_valid_d;
    logic                frame_partial_q, frame_partial_d;
    logic [FCNT_W-1:0]   frame_count_q,   frame_count_d;
    logic                in_ready_q,      in_ready_d;
    logic                accept;
    logic                sum_valid;

    // Collect samples, decide frame emission and the FILL/PAD transition.
    always_comb begin
        state_d         = state_q;
        fill_cnt_d      = fill_cnt_q;
        coll_d          = coll_q;
        pres_d          = '{default: '0};
        frame_valid_d   = 1'b0;
        frame_partial_d = 1'b0;
        frame_count_d   = frame_count_q;
        accept          = bus.in_valid & in_ready_q;

        unique case (state_q)
            FILL: begin
                if (accept) begin
                    coll_d[fill_cnt_q] = lane_t'(bus.in_data);
                    fill_cnt_d         = fill_cnt_q + cnt_t'(1);
                end
                // A completing accept wins over a same-cycle flush.
                if (accept && (fill_cnt_q == LAST_IDX)) begin
                    pres_d        = coll_d;
                    fill_cnt_d    = '0;
                    frame_valid_d = 1'b1;
                    frame_count_d = frame_count_q + FCNT_W'(1);
                end else if (bus.flush && (accept || (fill_cnt_q != '0))) begin
                    state_d = PAD;
                end
            end
            PAD: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    pres_d[i] = (cnt_t'(i) < fill_cnt_q) ? coll_q[i] : '0;
                end
                fill_cnt_d      = '0;
                frame_valid_d   = 1'b1;
                frame_partial_d = 1'b1;
                frame_count_d   = frame_count_q + FCNT_W'(1);
                state_d         = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        in_ready_d = (state_d == FILL);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= FILL;
            fill_cnt_q      <= '0;
            coll_q          <= '{default: '0};
            pres_q          <= '{default: '0};
            frame_valid_q   <= 1'b0;
            frame_partial_q <= 1'b0;
            frame_count_q   <= '0;
            in_ready_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            fill_cnt_q      <= fill_cnt_d;
            coll_q          <= coll_d;
            pres_q          <= pres_d;
            frame_valid_q   <= frame_valid_d;
            frame_partial_q <= frame_partial_d;
            frame_count_q   <= frame_count_d;
            in_ready_q      <= in_ready_d;
        end
    end

    // Align the frame flag with the tree's result latency.
    valid_delay #(
        .DEPTH(TREE_LAT)
    ) u_sum_valid (
        .clk(clk),
        .clr(rst),
        .d  (frame_valid_q),
        .q  (sum_valid)
    );

    assign bus.in_ready      = in_ready_q;
    assign bus.lane_0        = sample_t'(pres_q[0]);
    assign bus.lane_1        = sample_t'(pres_q[1]);
    assign bus.lane_2        = sample_t'(pres_q[2]);
    assign bus.lane_3        = sample_t'(pres_q[3]);
    assign bus.lane_4        = sample_t'(pres_q[4]);
    assign bus.lane_5        = sample_t'(pres_q[5]);
    assign bus.lane_6        = sample_t'(pres_q[6]);
    assign bus.lane_7        = sample_t'(pres_q[7]);
    assign bus.frame_valid   = frame_valid_q;
    assign bus.frame_partial = frame_partial_q;
    assign bus.sum_valid     = sum_valid;
    assign bus.frame_count   = frame_count_q;

endmodule
